// File: rtl/pgm_pkg.sv
// Shared constants for the packet-generator checker: word header fields,
// test-packet field positions and the checker FSM encoding.
package pgm_pkg;

  localparam int DATA_W     = 134;
  localparam int PHV_W      = 1024;
  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  localparam int HDR_HI   = 133;
  localparam int HDR_LO   = 132;
  localparam int INV_HI   = 131;
  localparam int INV_LO   = 128;
  localparam int TEST_BIT = 127;
  localparam int SEQ_HI   = 111;
  localparam int SEQ_LO   = 96;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } chk_state_t;

endpackage

// File: rtl/pgm_chk_phv_fifo.sv
// Four-entry show-ahead PHV buffer; dout is the oldest entry whenever count != 0.
module pgm_chk_phv_fifo
  import pgm_pkg::*;
#(
  parameter int W = PHV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [2:0]   count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  // A push into a full buffer is only taken when a pop frees a slot the same cycle.
  assign pop_ok  = pop && (count != 3'd0);
  assign push_ok = push && ((count != 3'(FIFO_DEPTH)) || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop_ok)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push_ok} - {2'b00, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pgm_chk.sv
// Test-packet checker: consumes generator packets and keeps receive statistics,
// forwards every other packet (with its PHV) after one register stage.
module pgm_chk
  import pgm_pkg::*;
#(
  parameter logic [7:0] LMID  = 8'd7,
  parameter int         SEQ_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_chk_data,
  input  logic                in_chk_data_wr,
  input  logic                in_chk_valid_wr,
  input  logic                in_chk_valid,
  output logic                out_chk_alf,
  input  logic [PHV_W-1:0]    in_chk_phv,
  input  logic                in_chk_phv_wr,
  output logic                out_chk_phv_alf,
  output logic [DATA_W-1:0]   out_chk_data,
  output logic                out_chk_data_wr,
  output logic                out_chk_valid_wr,
  output logic                out_chk_valid,
  input  logic                in_chk_alf,
  output logic [PHV_W-1:0]    out_chk_phv,
  output logic                out_chk_phv_wr,
  input  logic                in_chk_phv_alf,
  input  logic                in_chk_clr,
  input  logic [15:0]         in_chk_expect_num,
  output logic [31:0]         out_chk_pkt_cnt,
  output logic [47:0]         out_chk_byte_cnt,
  output logic [31:0]         out_chk_seq_err_cnt,
  output logic [31:0]         out_chk_drop_cnt,
  output logic [15:0]         out_chk_frm_err_cnt,
  output logic                out_chk_rcv_start_flag,
  output logic                out_chk_rcv_finish_flag
);

  // The sequence field is 16 bits wide in the header; module ID 0 means unassigned.
  if (SEQ_W < 1 || SEQ_W > 16 || LMID == 8'd0) begin : g_param_check
    $error("pgm_chk: SEQ_W must be 1..16 and LMID non-zero");
  end

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [31:0] b);
    logic [48:0] s;
    s = {1'b0, a} + {17'd0, b};
    return s[48] ? '1 : s[47:0];
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? '1 : s[15:0];
  endfunction

  chk_state_t state, state_nxt;
  logic [1:0] hdr;
  logic       is_head, is_tail, is_test;
  logic       fwd_word, drop_word, frm_head, force_tail;

  assign hdr     = in_chk_data[HDR_HI:HDR_LO];
  assign is_head = in_chk_data_wr && (hdr == HDR_HEAD);
  assign is_tail = in_chk_data_wr && (hdr == HDR_TAIL);
  assign is_test = in_chk_data[TEST_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A head always opens a new packet; in FWD/DROP it abandons the open one.
  always_comb begin
    state_nxt  = state;
    fwd_word   = 1'b0;
    drop_word  = 1'b0;
    frm_head   = 1'b0;
    force_tail = 1'b0;
    if (is_head) begin
      frm_head   = (state != IDLE);
      force_tail = (state == FWD);
      state_nxt  = is_test ? DROP : FWD;
      fwd_word   = !is_test;
      drop_word  = is_test;
    end else if (in_chk_data_wr) begin
      case (state)
        FWD: begin
          fwd_word = 1'b1;
          if (is_tail) state_nxt = IDLE;
        end
        DROP: begin
          drop_word = 1'b1;
          if (is_tail) state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  logic [2:0]       phv_count;
  logic [PHV_W-1:0] fifo_dout, phv_sel;
  logic             phv_empty, phv_avail, phv_push, phv_pop, phv_miss;

  // With an empty buffer, a PHV arriving alongside the head bypasses storage.
  assign phv_empty = (phv_count == 3'd0);
  assign phv_avail = !phv_empty || in_chk_phv_wr;
  assign phv_sel   = phv_empty ? in_chk_phv : fifo_dout;
  assign phv_pop   = is_head && !phv_empty;
  assign phv_push  = in_chk_phv_wr && !(is_head && phv_empty);
  assign phv_miss  = is_head && !phv_avail;

  pgm_chk_phv_fifo #(.W(PHV_W)) u_phv_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (phv_push),
    .din   (in_chk_phv),
    .pop   (phv_pop),
    .dout  (fifo_dout),
    .count (phv_count)
  );

  assign out_chk_alf     = in_chk_alf;
  assign out_chk_phv_alf = (phv_count >= 3'd3) || in_chk_phv_alf;

  // ---- forward stage: one register between input and output ----
  logic [DATA_W-1:0] data_p0;
  logic              wr_p0, vld_wr_p0, vld_p0, phv_wr_p0;
  logic [PHV_W-1:0]  phv_p0;
  logic              pkt_known, pkt_test;
  logic              fwd_vld;

  assign fwd_vld = in_chk_valid_wr && pkt_known && !pkt_test;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p0   <= '0;
      wr_p0     <= 1'b0;
      vld_wr_p0 <= 1'b0;
      vld_p0    <= 1'b0;
      phv_p0    <= '0;
      phv_wr_p0 <= 1'b0;
    end else begin
      wr_p0     <= fwd_word;
      vld_wr_p0 <= fwd_vld;
      vld_p0    <= fwd_vld && in_chk_valid;
      phv_wr_p0 <= fwd_word && is_head && phv_avail;
      if (fwd_word) data_p0 <= in_chk_data;
      if (fwd_word && is_head && phv_avail) phv_p0 <= phv_sel;
    end
  end

  // The abandoned packet's last word is still on the output during the head cycle.
  assign out_chk_data     = {(force_tail && wr_p0) ? HDR_TAIL : data_p0[HDR_HI:HDR_LO],
                             data_p0[INV_HI:0]};
  assign out_chk_data_wr  = wr_p0;
  assign out_chk_valid_wr = vld_wr_p0;
  assign out_chk_valid    = vld_p0;
  assign out_chk_phv      = phv_p0;
  assign out_chk_phv_wr   = phv_wr_p0;

  // ---- packet context: class, sequence and running byte sum of the open packet ----
  logic [SEQ_W-1:0] pkt_seq;
  logic [31:0]      pkt_bytes, word_bytes, bytes_now;

  assign word_bytes = is_tail ? 32'd16 - {28'd0, in_chk_data[INV_HI:INV_LO]} : 32'd16;
  assign bytes_now  = pkt_bytes + ((drop_word && !is_head) ? word_bytes : 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_known <= 1'b0;
      pkt_test  <= 1'b0;
    end else begin
      if (in_chk_valid_wr) pkt_known <= 1'b0;
      if (is_head) begin
        pkt_known <= 1'b1;
        pkt_test  <= is_test;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (is_head) begin
      pkt_seq   <= in_chk_data[SEQ_LO +: SEQ_W];
      pkt_bytes <= 32'd16;
    end else if (drop_word) begin
      pkt_bytes <= pkt_bytes + word_bytes;
    end
  end

  // ---- statistics stage ----
  logic [31:0]      pkt_cnt, seq_err_cnt, drop_cnt;
  logic [47:0]      byte_cnt;
  logic [15:0]      frm_err_cnt;
  logic [SEQ_W-1:0] exp_seq;
  logic             start_flag, started;
  logic             test_vld, good, bad;
  logic [1:0]       frm_inc;

  assign test_vld = in_chk_valid_wr && pkt_known && pkt_test;
  assign good     = test_vld && in_chk_valid;
  assign bad      = test_vld && !in_chk_valid;
  assign frm_inc  = {1'b0, frm_head} + {1'b0, phv_miss};

  always_ff @(posedge clk or posedge rst) begin
    if (rst || in_chk_clr) begin
      pkt_cnt     <= '0;
      byte_cnt    <= '0;
      seq_err_cnt <= '0;
      drop_cnt    <= '0;
      frm_err_cnt <= '0;
      exp_seq     <= '0;
      start_flag  <= 1'b0;
      started     <= 1'b0;
    end else begin
      if (good) begin
        pkt_cnt  <= sat_inc32(pkt_cnt);
        byte_cnt <= sat_add48(byte_cnt, bytes_now);
        exp_seq  <= pkt_seq + SEQ_W'(1);
        if (pkt_seq != exp_seq) seq_err_cnt <= sat_inc32(seq_err_cnt);
      end
      if (bad) drop_cnt <= sat_inc32(drop_cnt);
      frm_err_cnt <= sat_add16(frm_err_cnt, frm_inc);
      start_flag  <= is_head && is_test && !started;
      if (is_head && is_test) started <= 1'b1;
    end
  end

  assign out_chk_pkt_cnt         = pkt_cnt;
  assign out_chk_byte_cnt        = byte_cnt;
  assign out_chk_seq_err_cnt     = seq_err_cnt;
  assign out_chk_drop_cnt        = drop_cnt;
  assign out_chk_frm_err_cnt     = frm_err_cnt;
  assign out_chk_rcv_start_flag  = start_flag;
  assign out_chk_rcv_finish_flag = (in_chk_expect_num != 16'd0) &&
                                   (pkt_cnt >= {16'd0, in_chk_expect_num});

endmodule

// File: tb/tb_pgm_chk.sv
// Bench for pgm_chk: directed scenarios plus randomized packet traffic checked
// against a packet-level reference model.
module tb_pgm_chk;

  logic          clk, rst;
  logic [133:0]  in_chk_data;
  logic          in_chk_data_wr, in_chk_valid_wr, in_chk_valid;
  logic          out_chk_alf;
  logic [1023:0] in_chk_phv;
  logic          in_chk_phv_wr, out_chk_phv_alf;
  logic [133:0]  out_chk_data;
  logic          out_chk_data_wr, out_chk_valid_wr, out_chk_valid;
  logic          in_chk_alf;
  logic [1023:0] out_chk_phv;
  logic          out_chk_phv_wr, in_chk_phv_alf, in_chk_clr;
  logic [15:0]   in_chk_expect_num;
  logic [31:0]   out_chk_pkt_cnt, out_chk_seq_err_cnt, out_chk_drop_cnt;
  logic [47:0]   out_chk_byte_cnt;
  logic [15:0]   out_chk_frm_err_cnt;
  logic          out_chk_rcv_start_flag, out_chk_rcv_finish_flag;

  pgm_chk dut (
    .clk(clk), .rst(rst),
    .in_chk_data(in_chk_data), .in_chk_data_wr(in_chk_data_wr),
    .in_chk_valid_wr(in_chk_valid_wr), .in_chk_valid(in_chk_valid),
    .out_chk_alf(out_chk_alf),
    .in_chk_phv(in_chk_phv), .in_chk_phv_wr(in_chk_phv_wr),
    .out_chk_phv_alf(out_chk_phv_alf),
    .out_chk_data(out_chk_data), .out_chk_data_wr(out_chk_data_wr),
    .out_chk_valid_wr(out_chk_valid_wr), .out_chk_valid(out_chk_valid),
    .in_chk_alf(in_chk_alf),
    .out_chk_phv(out_chk_phv), .out_chk_phv_wr(out_chk_phv_wr),
    .in_chk_phv_alf(in_chk_phv_alf), .in_chk_clr(in_chk_clr),
    .in_chk_expect_num(in_chk_expect_num),
    .out_chk_pkt_cnt(out_chk_pkt_cnt), .out_chk_byte_cnt(out_chk_byte_cnt),
    .out_chk_seq_err_cnt(out_chk_seq_err_cnt), .out_chk_drop_cnt(out_chk_drop_cnt),
    .out_chk_frm_err_cnt(out_chk_frm_err_cnt),
    .out_chk_rcv_start_flag(out_chk_rcv_start_flag),
    .out_chk_rcv_finish_flag(out_chk_rcv_finish_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (low 136 bits)", tag, act[135:0], exp[135:0]);
    end
  endtask

  // Reference model state (packet level)
  typedef struct {
    logic [133:0]  data;
    bit            phv_wr;
    logic [1023:0] phv;
    int            cyc;
  } word_t;
  typedef struct {
    bit valid;
    int cyc;
  } vld_t;

  word_t         exp_q[$];
  vld_t          vexp_q[$];
  logic [1023:0] phv_q[$];
  longint        m_pkt, m_byte, m_seqerr, m_drop, m_frm;
  logic [15:0]   m_exp_seq;
  bit            m_started;
  int            m_starts, exp_start_cyc;
  int            words_seen = 0, words_exp = 0;
  int            start_cnt = 0, start_last_cyc = -1;

  // Output monitor: every forwarded word and valid strobe must match the model queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_chk_data_wr) begin
        words_seen++;
        if (exp_q.size() == 0) chk("unexp_word", words_seen, words_exp);
        else begin
          word_t e;
          e = exp_q.pop_front();
          chk("data", out_chk_data, e.data);
          chk("lat", cyc, e.cyc);
          chk("phv_wr", out_chk_phv_wr, e.phv_wr);
          if (e.phv_wr) chk("phv", out_chk_phv, e.phv);
        end
      end else if (out_chk_phv_wr) begin
        chk("stray_phv", out_chk_phv_wr, 1'b0);
      end
      if (out_chk_valid_wr) begin
        if (vexp_q.size() == 0) chk("unexp_valid", out_chk_valid_wr, 1'b0);
        else begin
          vld_t v;
          v = vexp_q.pop_front();
          chk("valid", out_chk_valid, v.valid);
          chk("vlat", cyc, v.cyc);
        end
      end
      if (out_chk_rcv_start_flag) begin
        start_cnt++;
        start_last_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    in_chk_data_wr  = 1'b0;
    in_chk_valid_wr = 1'b0;
    in_chk_phv_wr   = 1'b0;
    in_chk_clr      = 1'b0;
  endtask

  task automatic model_clear();
    m_pkt = 0; m_byte = 0; m_seqerr = 0; m_drop = 0; m_frm = 0;
    m_exp_seq = 16'd0; m_started = 0; m_starts = 0; start_cnt = 0;
  endtask

  task automatic do_clear();
    in_chk_clr = 1'b1;
    model_clear();
    step();
  endtask

  function automatic logic [1023:0] rand_phv();
    logic [1023:0] p;
    for (int i = 0; i < 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic logic [133:0] mk_word(input logic [1:0] hdr, input bit test,
                                           input logic [15:0] seq, input logic [3:0] inv);
    logic [159:0] r;
    logic [133:0] w;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w = r[133:0];
    w[133:132] = hdr;
    if (hdr == 2'b10) w[131:128] = inv;
    if (hdr == 2'b01) begin
      w[127]    = test;
      w[111:96] = seq;
    end
    return w;
  endfunction

  task automatic push_phv_only();
    logic [1023:0] p;
    p = rand_phv();
    in_chk_phv = p; in_chk_phv_wr = 1'b1;
    phv_q.push_back(p);
    step();
  endtask

  task automatic push_exp(input logic [133:0] d, input bit pw, input logic [1023:0] pv);
    word_t e;
    e.data = d; e.phv_wr = pw; e.phv = pv; e.cyc = cyc + 1;
    exp_q.push_back(e);
    words_exp++;
  endtask

  // Model for the head: PHV taken from the pending queue, else the same-cycle one, else a miss.
  task automatic head_phv(input int phv_mode, input logic [1023:0] p,
                          output bit pw, output logic [1023:0] pv);
    pw = 0; pv = '0;
    if (phv_q.size() > 0) begin pw = 1; pv = phv_q.pop_front(); end
    else if (phv_mode == 2) begin pw = 1; pv = p; end
    if (phv_mode == 2) begin
      in_chk_phv = p; in_chk_phv_wr = 1'b1;
      if (pv !== p) phv_q.push_back(p);
    end
    if (!pw) m_frm++;
  endtask

  // phv_mode: 0 no PHV, 1 PHV one cycle ahead of the head, 2 PHV with the head.
  task automatic send_pkt(input bit test, input logic [15:0] seq, input int nw,
                          input logic [3:0] inv, input bit valid, input int phv_mode,
                          input bit late_valid);
    logic [1023:0] p, pv;
    logic [133:0]  w;
    bit            pw;
    p = rand_phv();
    if (phv_mode == 1) begin
      in_chk_phv = p; in_chk_phv_wr = 1'b1;
      phv_q.push_back(p);
      step();
    end
    for (int i = 0; i < nw; i++) begin
      pw = 0; pv = '0;
      w = mk_word((i == 0) ? 2'b01 : (i == nw - 1) ? 2'b10 : 2'b11, test, seq, inv);
      in_chk_data = w; in_chk_data_wr = 1'b1;
      if (i == 0) begin
        head_phv(phv_mode, p, pw, pv);
        if (test && !m_started) begin
          m_started = 1; m_starts++; exp_start_cyc = cyc + 1;
        end
      end
      if (!test) push_exp(w, pw, pv);
      if (i == nw - 1 && late_valid) step();
      if (i == nw - 1) begin
        in_chk_valid_wr = 1'b1; in_chk_valid = valid;
        if (test) begin
          if (valid) begin
            m_pkt++;
            m_byte += 16 * nw - inv;
            if (seq != m_exp_seq) m_seqerr++;
            m_exp_seq = seq + 16'd1;
          end else m_drop++;
        end else begin
          vld_t v;
          v.valid = valid; v.cyc = cyc + 1;
          vexp_q.push_back(v);
        end
      end
      step();
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_pkt"}, out_chk_pkt_cnt, m_pkt);
    chk({tag, "_byte"}, out_chk_byte_cnt, m_byte);
    chk({tag, "_seqerr"}, out_chk_seq_err_cnt, m_seqerr);
    chk({tag, "_drop"}, out_chk_drop_cnt, m_drop);
    chk({tag, "_frm"}, out_chk_frm_err_cnt, m_frm);
  endtask

  initial begin
    int snap;
    logic [133:0] h1, h2, t2;
    logic [1023:0] pv;
    bit pw;
    rst = 1'b1;
    in_chk_data = '0; in_chk_data_wr = 0; in_chk_valid_wr = 0; in_chk_valid = 0;
    in_chk_phv = '0; in_chk_phv_wr = 0; in_chk_alf = 0; in_chk_phv_alf = 0;
    in_chk_clr = 0; in_chk_expect_num = 16'd0;
    model_clear();
    @(posedge clk); #1;
    chk("rst_wr", out_chk_data_wr, 0);
    chk("rst_data", out_chk_data, 0);
    chk("rst_pkt", out_chk_pkt_cnt, 0);
    chk("rst_frm", out_chk_frm_err_cnt, 0);
    chk("rst_phv_alf", out_chk_phv_alf, 0);
    chk("rst_start", out_chk_rcv_start_flag, 0);
    chk("rst_finish", out_chk_rcv_finish_flag, 0);
    step(); rst = 1'b0; step();

    // Three good test packets, 4 words, 6 invalid bytes on tail
    snap = words_seen;
    for (int i = 0; i < 3; i++) send_pkt(1, 16'(i), 4, 4'd6, 1, 1, 0);
    step();
    chk("r22_pkt", out_chk_pkt_cnt, 3);
    chk("r22_byte", out_chk_byte_cnt, 174);
    chk("r22_seqerr", out_chk_seq_err_cnt, 0);
    chk("r22_noout", words_seen, snap);
    chk_stats("r22");

    // Sequence 5,6,8 after clear, then 9 (expected after 8)
    do_clear();
    send_pkt(1, 16'd5, 3, 4'd0, 1, 2, 0);
    send_pkt(1, 16'd6, 3, 4'd0, 1, 2, 0);
    send_pkt(1, 16'd8, 3, 4'd0, 1, 2, 0);
    step();
    chk("r23_seqerr", out_chk_seq_err_cnt, 2);
    send_pkt(1, 16'd9, 2, 4'd3, 1, 1, 0);
    step();
    chk("r23_seq9", out_chk_seq_err_cnt, 2);
    chk_stats("r23");

    // Sequence wrap 0xFFFF -> 0x0000
    do_clear();
    send_pkt(1, 16'hFFFF, 2, 4'd0, 1, 1, 0);
    step();
    chk("r25_ffff", out_chk_seq_err_cnt, 1);
    send_pkt(1, 16'h0000, 2, 4'd0, 1, 1, 0);
    step();
    chk("r25_wrap", out_chk_seq_err_cnt, 1);

    // Non-test 3-word packet with PHV (monitor checks words, latency and PHV)
    send_pkt(0, 16'd0, 3, 4'd2, 1, 1, 0);
    step(); step();

    // Head, head, tail on a non-test stream
    do_clear();
    push_phv_only(); push_phv_only();
    h1 = mk_word(2'b01, 0, 16'd0, 4'd0);
    in_chk_data = h1; in_chk_data_wr = 1;
    head_phv(0, '0, pw, pv);
    push_exp(h1, pw, pv);
    step();
    h2 = mk_word(2'b01, 0, 16'd0, 4'd0);
    in_chk_data = h2; in_chk_data_wr = 1;
    begin
      word_t t;
      t = exp_q.pop_back();
      t.data[133:132] = 2'b10;
      exp_q.push_back(t);
    end
    m_frm++;
    head_phv(0, '0, pw, pv);
    push_exp(h2, pw, pv);
    step();
    t2 = mk_word(2'b10, 0, 16'd0, 4'd5);
    in_chk_data = t2; in_chk_data_wr = 1; in_chk_valid_wr = 1; in_chk_valid = 1;
    push_exp(t2, 0, '0);
    begin
      vld_t v;
      v.valid = 1; v.cyc = cyc + 1;
      vexp_q.push_back(v);
    end
    step(); step();
    chk("r27_frm", out_chk_frm_err_cnt, 1);

    // PHV almost-full threshold and passthroughs
    push_phv_only(); push_phv_only();
    chk("phv_alf2", out_chk_phv_alf, 0);
    push_phv_only();
    chk("phv_alf3", out_chk_phv_alf, 1);
    for (int i = 0; i < 3; i++) send_pkt(0, 16'd0, 2, 4'd1, 1, 0, 0);
    in_chk_phv_alf = 1; #1;
    chk("phv_alf_in", out_chk_phv_alf, 1);
    in_chk_phv_alf = 0; in_chk_alf = 1; #1;
    chk("alf_in", out_chk_alf, 1);
    in_chk_alf = 0;
    step();
    chk_stats("phv");

    // expect_num=2: start pulse, finish level, clear
    do_clear();
    in_chk_expect_num = 16'd2;
    send_pkt(1, 16'd0, 3, 4'd0, 1, 1, 0);
    chk("r26_fin1", out_chk_rcv_finish_flag, 0);
    send_pkt(1, 16'd1, 3, 4'd0, 1, 1, 0);
    chk("r26_fin2", out_chk_rcv_finish_flag, 1);
    chk("r26_starts", start_cnt, 1);
    chk("r26_start_cyc", start_last_cyc, exp_start_cyc);
    do_clear();
    chk("r26_clr_fin", out_chk_rcv_finish_flag, 0);
    chk("r26_clr_pkt", out_chk_pkt_cnt, 0);

    // Randomized traffic
    do_clear();
    in_chk_expect_num = 16'($urandom_range(1, 30));
    for (int n = 0; n < 60; n++) begin
      bit tst, vl, late;
      int nw, mode;
      logic [15:0] sq;
      tst  = ($urandom % 2) == 1;
      nw   = $urandom_range(2, 6);
      vl   = ($urandom % 4) != 0;
      late = ($urandom % 3) == 0;
      mode = (($urandom % 8) == 0) ? 0 : $urandom_range(1, 2);
      sq   = (($urandom % 5) == 0) ? 16'($urandom) : m_exp_seq;
      in_chk_alf = $urandom % 2;
      send_pkt(tst, sq, nw, 4'($urandom_range(0, 15)), vl, mode, late);
      chk("rnd_alf", out_chk_alf, in_chk_alf);
      repeat ($urandom_range(0, 2)) step();
    end
    step(); step();
    chk_stats("rnd");
    chk("rnd_fin", out_chk_rcv_finish_flag,
        (in_chk_expect_num != 0) && (m_pkt >= in_chk_expect_num));
    chk("rnd_starts", start_cnt, m_starts);

    // Asynchronous reset in the middle of a packet, then resume
    in_chk_data = mk_word(2'b01, 0, 16'd0, 4'd0); in_chk_data_wr = 1;
    head_phv(2, rand_phv(), pw, pv);
    push_exp(in_chk_data, pw, pv);
    step();
    @(negedge clk); #1;
    rst = 1'b1; #1;
    chk("arst_wr", out_chk_data_wr, 0);
    chk("arst_data", out_chk_data, 0);
    chk("arst_phv_wr", out_chk_phv_wr, 0);
    chk("arst_pkt", out_chk_pkt_cnt, 0);
    chk("arst_byte", out_chk_byte_cnt, 0);
    chk("arst_drop", out_chk_drop_cnt, 0);
    model_clear();
    phv_q.delete();
    step(); step();
    rst = 1'b0;
    in_chk_data = mk_word(2'b11, 0, 16'd0, 4'd0); in_chk_data_wr = 1;
    step();
    in_chk_data = mk_word(2'b10, 0, 16'd0, 4'd4); in_chk_data_wr = 1;
    in_chk_valid_wr = 1; in_chk_valid = 1;
    step(); step();
    chk_stats("arst");
    send_pkt(0, 16'd0, 3, 4'd7, 1, 2, 0);
    send_pkt(1, 16'd0, 2, 4'd0, 1, 1, 0);
    step(); step();
    chk_stats("post");

    chk("words_total", words_seen, words_exp);
    chk("exp_q_left", exp_q.size(), 0);
    chk("vexp_q_left", vexp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
